serial_byte_rx: RTL and testbench
=================================

// Module: serial_byte_rx
// PURPOSE
//  Receive end of the team's single-wire serial byte link (idle-high line, LSB-first framing).
//  Recovers bytes from the rx line, checks framing and presents each byte on a valid/ready output port.
//  Sits between the link pin and byte-wide consumer logic (register file, RAM loader).
// PARAMETERS
//  DATA_BITS     8  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clk cycles per serial bit (>=2); HALF = CLKS_PER_BIT/2 (integer division)
// PORTS
//  clk        in   1          single clock; all state changes on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  rx         in   1          serial line; idle 1, asynchronous to clk
//  out_data   out  DATA_BITS  received byte; stable while out_valid=1
//  out_valid  out  1          byte available
//  out_ready  in   1          consumer accepts the byte when out_valid && out_ready at a clk edge
//  frame_err  out  1          1-cycle pulse: stop bit sampled 0
//  overrun    out  1          1-cycle pulse: new byte dropped because the output was still full
// BEHAVIOUR
//  Reset: state IDLE, out_data=0, out_valid=0, frame_err=0, overrun=0, sync flops=1, counters=0.
//   Any frame in progress is abandoned; nothing is delivered for it.
//  Input: rx passes a 2-flop synchronizer (rxs); all decisions use rxs (2-cycle input latency).
//  FSM:
//   IDLE : rxs==0 -> START, cnt=0.
//   START: count HALF cycles; at the last one sample rxs: 0 -> DATA (cnt=0, idx=0); 1 -> IDLE (glitch, silent).
//   DATA : sample rxs every CLKS_PER_BIT cycles into shift reg (new bit in at MSB, shift right => LSB first);
//          after DATA_BITS samples -> STOP.
//   STOP : sample rxs after CLKS_PER_BIT cycles, then -> IDLE the same edge.
//          rxs==1 -> deliver; rxs==0 -> frame_err=1 for one cycle, byte discarded.
//  Line held low (break): repeated frame_err, one per frame time; no deadlock.
//  Delivery (stop-sample edge):
//   out_valid==0                   -> out_data<=shift reg, out_valid<=1 (visible the cycle after the sample).
//   out_valid==1 && out_ready==1   -> accepted byte replaced by new byte; out_valid stays 1.
//   out_valid==1 && out_ready==0   -> new byte dropped, old byte kept; overrun=1 for one cycle.
//  Handshake: out_valid && out_ready at edge with no delivery -> out_valid<=0 next cycle.
//   out_valid never drops without acceptance. out_data unchanged while out_valid=1 and not accepted.
//  Counters: cnt width clog2(CLKS_PER_BIT); idx width clog2(DATA_BITS+1); both wrap only via explicit reset to 0.
//  frame_err and overrun are never asserted in the same cycle as each other.
// STRUCTURE
//  Package serial_link_pkg: rx_state_t enum {IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3},
//   LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1 (shared with the link transmitter).
//  Sub-module sync_2ff (2-flop synchronizer, reset value parameter, async active-low reset).
//   Instantiated once on rx with reset value 1.
//  FSM, bit counter, shift register and output holding register stay in serial_byte_rx.
// TESTING (DATA_BITS=8, CLKS_PER_BIT=4, each serial bit held 4 clk cycles)
//  1. rst_n=0 while rx toggles -> out_valid=0, frame_err=0, overrun=0, out_data=8'h00 throughout.
//  2. Frame 8'hA5, out_ready=1 -> out_valid high exactly 1 cycle with out_data=8'hA5; no error pulses.
//  3. rx low for 1 cycle only -> no out_valid, no frame_err; a following frame 8'h5A is received correctly.
//  4. Frame 8'h3C with stop bit 0 -> frame_err pulses 1 cycle, out_valid stays 0.
//  5. out_ready=0, frames 8'h11 then 8'h22 -> out_data=8'h11 held, overrun pulses once;
//     out_ready=1 -> 8'h11 accepted, out_valid drops next cycle.
//  6. rst_n pulsed low mid-DATA of 8'hFF, then frame 8'h42 -> only 8'h42 delivered.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial byte link (idle-high line, LSB-first frames).
// Used by both the receiver and the link transmitter.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value lets an idle-high line come out of reset without a false edge.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state uses non-blocking (<=) so both flops sample the pre-edge values;
  // blocking assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// Receive end of the serial byte link: synchronizes rx, recovers LSB-first frames,
// checks the stop bit and presents each byte on a valid/ready port with overrun detection.
module serial_byte_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(
    .RESET_VALUE(LINE_IDLE)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset along with the control state so a frame cut
      // short by reset can never leak stale bits into a later delivery.
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Plain acceptance; a delivery on the same edge below overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rxs == START_BIT) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= (rxs == START_BIT) ? DATA : IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            shift_reg <= (shift_reg >> 1) | (DATA_BITS'(rxs) << (DATA_BITS - 1));
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxs == STOP_BIT) begin
              // Deliver into an empty slot or in place of the byte being accepted now.
              if (!out_valid || out_ready) begin
                out_data  <= shift_reg;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed plus randomized bench for serial_byte_rx; frames are built from the line protocol
// and delivered bytes are compared against a queue of expected bytes.
module tb_serial_byte_rx;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic [7:0] expq[$];
  int         valid_cycles, fe_count, ov_count, both_count, hold_viol;
  logic       prev_valid, prev_ready;
  logic [7:0] prev_data;

  serial_byte_rx #(
    .DATA_BITS   (DATA_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge: record accepted bytes, pulses and handshake violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) got.push_back(out_data);
      valid_cycles += int'(out_valid);
      fe_count     += int'(frame_err);
      ov_count     += int'(overrun);
      both_count   += int'(frame_err && overrun);
      if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data)) hold_viol++;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    valid_cycles = 0;
    fe_count     = 0;
    ov_count     = 0;
    both_count   = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLKS_PER_BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int fe_exp;
    logic [7:0] d;
    logic good;

    hold_viol = 0;
    rst_n     = 1'b0;
    rx        = 1'b1;
    out_ready = 1'b0;
    clear_stats();

    // Reset held while the line toggles: outputs stay at reset values.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 rx = 1'($urandom);
      @(negedge clk);
      check("reset_outputs", {21'h0, out_valid, frame_err, overrun, out_data}, 32'h0);
    end
    @(posedge clk);
    #1 rx = 1'b1;
    rst_n = 1'b1;
    idle(6);

    // Single good frame with the consumer always ready.
    clear_stats();
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(8);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_count", got.size(), 1);
    check("a5_data", got_at(0), 32'hA5);
    check("a5_no_errs", fe_count + ov_count, 0);

    // One-cycle glitch is ignored, following frame still received.
    clear_stats();
    rx = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    check("glitch_no_valid", valid_cycles, 0);
    check("glitch_no_fe", fe_count, 0);
    send_frame(8'h5A, 1'b1);
    idle(8);
    check("after_glitch_count", got.size(), 1);
    check("after_glitch_data", got_at(0), 32'h5A);

    // Bad stop bit: one frame_err pulse, nothing delivered.
    clear_stats();
    send_frame(8'h3C, 1'b0);
    idle(8);
    check("bad_stop_fe", fe_count, 1);
    check("bad_stop_no_valid", valid_cycles, 0);

    // Consumer stalled: first byte held, second dropped with one overrun pulse.
    clear_stats();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(6);
    send_frame(8'h22, 1'b1);
    idle(8);
    @(negedge clk);
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 32'h11);
    check("stall_overrun", ov_count, 1);
    check("stall_no_fe", fe_count, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("accept_drops_valid", out_valid, 0);
    check("accept_count", got.size(), 1);
    check("accept_data", got_at(0), 32'h11);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame of 0xFF: that frame is never delivered.
    clear_stats();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {22'h0, out_valid, frame_err, out_data}, 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    send_frame(8'h42, 1'b1);
    idle(8);
    check("midreset_count", got.size(), 1);
    check("midreset_data", got_at(0), 32'h42);
    check("midreset_no_fe", fe_count, 0);

    // Line held low: one frame error per frame time, then normal reception resumes.
    clear_stats();
    rx = 1'b0;
    repeat (160) @(posedge clk);
    #1;
    idle(60);
    check("break_fe_per_frame", (fe_count >= 3 && fe_count <= 5), 1);
    got.delete();
    send_frame(8'h77, 1'b1);
    idle(8);
    check("after_break_count", got.size(), 1);
    check("after_break_data", got_at(0), 32'h77);

    // Random frames with occasional bad stop bits against the expected-byte queue.
    clear_stats();
    expq.delete();
    fe_exp = 0;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(d, good);
      if (good) expq.push_back(d);
      else      fe_exp++;
      idle($urandom_range(4, 12));
    end
    idle(10);
    check("rand_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) check("rand_data", got_at(i), {24'h0, expq[i]});
    check("rand_fe", fe_count, fe_exp);
    check("rand_no_overrun", ov_count, 0);
    check("rand_no_both", both_count, 0);
    check("hold_stable", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
